conv_job_scheduler: RTL

CONV_JOB_SCHEDULER -- requirements
Module: conv_job_scheduler

---
 rtl/conv_job_scheduler_if.sv | 29 ++
 rtl/conv_job_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/conv_job_scheduler_if.sv
// Scheduler-side bundle: run/busy handshake, input-SRAM read port and the
// convolution-engine job port. Signal names match the legacy flat ports.
interface conv_job_scheduler_if;
  logic        dut_run;
  logic        dut_busy;
  logic [11:0] dut_sram_read_address;
  logic [15:0] sram_dut_read_data;
  logic [11:0] eng_read_address;
  logic        eng_start;
  logic [4:0]  eng_nrows;
  logic [4:0]  eng_ncols;
  logic [11:0] eng_raddr_base;
  logic [11:0] eng_waddr_base;
  logic        eng_done;
  logic        err_dims;
  logic [7:0]  job_count;

  modport master (
    input  dut_run, sram_dut_read_data, eng_read_address, eng_done,
    output dut_busy, dut_sram_read_address, eng_start, eng_nrows, eng_ncols,
           eng_raddr_base, eng_waddr_base, err_dims, job_count
  );

  modport slave (
    output dut_run, sram_dut_read_data, eng_read_address, eng_done,
    input  dut_busy, dut_sram_read_address, eng_start, eng_nrows, eng_ncols,
           eng_raddr_base, eng_waddr_base, err_dims, job_count
  );
endinterface

// File: rtl/conv_job_scheduler.sv
// Walks a packed list of images in input SRAM (nrows, ncols, row words) and
// launches one engine job per image until the end-marker word is read.
module conv_job_scheduler #(
  parameter logic [15:0] END_MARKER = 16'h00FF,
  parameter int unsigned MIN_DIM    = 3,
  parameter int unsigned MAX_DIM    = 16
) (
  input logic                  clk,
  input logic                  reset_b,
  conv_job_scheduler_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_R  = 3'd1;
  localparam logic [2:0] S_REQ_C  = 3'd2;
  localparam logic [2:0] S_CHK    = 3'd3;
  localparam logic [2:0] S_LAUNCH = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_ADV    = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [4:0] MIN_D = 5'(MIN_DIM);
  localparam logic [4:0] MAX_D = 5'(MAX_DIM);

  logic [2:0]  state_q, state_d;
  logic        busy_q, busy_d;
  logic [11:0] img_base_q, img_base_d;
  logic [11:0] out_base_q, out_base_d;
  logic [11:0] addr_q, addr_d;
  logic [11:0] raddr_base_q, raddr_base_d;
  logic [11:0] waddr_base_q, waddr_base_d;
  logic [4:0]  nrows_q, nrows_d;
  logic [4:0]  ncols_q, ncols_d;
  logic        nrows_hi_q, nrows_hi_d;
  logic        err_q, err_d;
  logic [7:0]  job_count_q, job_count_d;
  logic [15:0] rdata;
  logic        dims_bad;

  assign rdata = bus.sram_dut_read_data;

  // nrows upper bits were seen a cycle earlier, so they are carried in a flag.
  assign dims_bad = nrows_hi_q | (|rdata[15:5])
                  | (nrows_q < MIN_D) | (nrows_q > MAX_D)
                  | (rdata[4:0] < MIN_D) | (rdata[4:0] > MAX_D);

  always_comb begin
    state_d      = state_q;
    img_base_d   = img_base_q;
    out_base_d   = out_base_q;
    raddr_base_d = raddr_base_q;
    waddr_base_d = waddr_base_q;
    nrows_d      = nrows_q;
    ncols_d      = ncols_q;
    nrows_hi_d   = nrows_hi_q;
    err_d        = err_q;
    job_count_d  = job_count_q;
    addr_d       = addr_q;

    case (state_q)
      S_IDLE: begin
        // busy_q still high for one cycle after DONE: blocks an instant re-run
        if (bus.dut_run && !busy_q) begin
          img_base_d  = '0;
          out_base_d  = '0;
          job_count_d = '0;
          err_d       = 1'b0;
          state_d     = S_REQ_R;
        end
      end
      S_REQ_R: begin
        addr_d  = img_base_q;
        state_d = S_REQ_C;
      end
      S_REQ_C: begin
        addr_d = img_base_q + 12'd1;
        if (rdata == END_MARKER) begin
          state_d = S_DONE;
        end else begin
          nrows_d    = rdata[4:0];
          nrows_hi_d = |rdata[15:5];
          state_d    = S_CHK;
        end
      end
      S_CHK: begin
        ncols_d = rdata[4:0];
        if (dims_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          raddr_base_d = img_base_q + 12'd2;
          waddr_base_d = out_base_q;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        addr_d = bus.eng_read_address;
        if (bus.eng_done) state_d = S_ADV;
      end
      S_ADV: begin
        img_base_d = img_base_q + 12'd2 + {7'd0, nrows_q};
        out_base_d = out_base_q + {7'd0, nrows_q} - 12'd2;
        if (job_count_q != '1) job_count_d = job_count_q + 8'd1;
        state_d = S_REQ_R;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      img_base_q   <= '0;
      out_base_q   <= '0;
      addr_q       <= '0;
      raddr_base_q <= '0;
      waddr_base_q <= '0;
      nrows_q      <= '0;
      ncols_q      <= '0;
      nrows_hi_q   <= 1'b0;
      err_q        <= 1'b0;
      job_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      img_base_q   <= img_base_d;
      out_base_q   <= out_base_d;
      addr_q       <= addr_d;
      raddr_base_q <= raddr_base_d;
      waddr_base_q <= waddr_base_d;
      nrows_q      <= nrows_d;
      ncols_q      <= ncols_d;
      nrows_hi_q   <= nrows_hi_d;
      err_q        <= err_d;
      job_count_q  <= job_count_d;
    end
  end

  assign bus.dut_busy              = busy_q;
  assign bus.dut_sram_read_address = addr_d;
  assign bus.eng_start             = (state_q == S_LAUNCH);
  assign bus.eng_nrows             = nrows_q;
  assign bus.eng_ncols             = ncols_q;
  assign bus.eng_raddr_base        = raddr_base_q;
  assign bus.eng_waddr_base        = waddr_base_q;
  assign bus.err_dims              = err_q;
  assign bus.job_count             = job_count_q;

endmodule
